// File: rtl/shared_mem_port_ctrl_pkg.sv
// Shared types and default widths for the shared memory port controller.
// State encoding is fixed at 2 bits.
package shared_mem_port_ctrl_pkg;

    localparam int DEF_NUM_PORTS       = 4;
    localparam int DEF_NUM_PORTS_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH      = 16;
    localparam int DEF_DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } ctrlState_e;

endpackage

// File: rtl/shared_mem_port_ctrl_port_field_mux.sv
// Selects one port's field out of a flattened per-port bus.
// Reused for address, write data and write enable.
module port_field_mux
    import shared_mem_port_ctrl_pkg::*;
#(
    parameter int NUM_PORTS       = DEF_NUM_PORTS,
    parameter int NUM_PORTS_WIDTH = DEF_NUM_PORTS_WIDTH,
    parameter int FIELD_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic [NUM_PORTS*FIELD_WIDTH-1:0] iBus,
    input  logic [NUM_PORTS_WIDTH-1:0]       iSel,
    output logic [FIELD_WIDTH-1:0]           oField
);

    always_comb begin
        oField = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (iSel == NUM_PORTS_WIDTH'(i)) begin
                oField = iBus[i*FIELD_WIDTH +: FIELD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/shared_mem_port_ctrl.sv
// Serialises arbiter grants onto a single shared memory port.
// One transaction per IDLE-ISSUE-RESP-DRAIN pass.
module shared_mem_port_ctrl
    import shared_mem_port_ctrl_pkg::*;
#(
    parameter int NUM_PORTS       = DEF_NUM_PORTS,
    parameter int NUM_PORTS_WIDTH = DEF_NUM_PORTS_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
    input  logic                            iClk,
    input  logic                            iReset,
    input  logic                            iActive,
    input  logic [NUM_PORTS_WIDTH-1:0]      iSelected,
    output logic                            oPortBusy,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] iAddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] iWriteData,
    input  logic [NUM_PORTS-1:0]            iWriteEnable,
    output logic                            oMemRequest,
    output logic [ADDR_WIDTH-1:0]           oMemAddr,
    output logic [DATA_WIDTH-1:0]           oMemWriteData,
    output logic                            oMemWriteEnable,
    input  logic                            iMemAck,
    input  logic [DATA_WIDTH-1:0]           iMemReadData,
    output logic [DATA_WIDTH-1:0]           oReadData,
    output logic [NUM_PORTS-1:0]            oReadValid,
    output logic [NUM_PORTS-1:0]            oWriteDone
);

    ctrlState_e state, stateNext;

    logic [NUM_PORTS_WIDTH-1:0] holdIdx, holdIdxD;
    logic                       holdWe, holdWeD;
    logic [ADDR_WIDTH-1:0]      selAddr, addrD;
    logic [DATA_WIDTH-1:0]      selData, wdataD, rdataD;
    logic [0:0]                 selWe;
    logic                       reqD, weD;
    logic [NUM_PORTS-1:0]       validD, doneD;
    logic                       legalGrant;

    port_field_mux #(
        .NUM_PORTS       (NUM_PORTS),
        .NUM_PORTS_WIDTH (NUM_PORTS_WIDTH),
        .FIELD_WIDTH     (ADDR_WIDTH)
    ) uAddrMux (
        .iBus   (iAddr),
        .iSel   (iSelected),
        .oField (selAddr)
    );

    port_field_mux #(
        .NUM_PORTS       (NUM_PORTS),
        .NUM_PORTS_WIDTH (NUM_PORTS_WIDTH),
        .FIELD_WIDTH     (DATA_WIDTH)
    ) uDataMux (
        .iBus   (iWriteData),
        .iSel   (iSelected),
        .oField (selData)
    );

    port_field_mux #(
        .NUM_PORTS       (NUM_PORTS),
        .NUM_PORTS_WIDTH (NUM_PORTS_WIDTH),
        .FIELD_WIDTH     (1)
    ) uWeMux (
        .iBus   (iWriteEnable),
        .iSel   (iSelected),
        .oField (selWe)
    );

    // Out-of-range indices only exist when NUM_PORTS is not a power of two.
    if (NUM_PORTS < (1 << NUM_PORTS_WIDTH)) begin : gRangeCheck
        assign legalGrant = iActive &&
            ({1'b0, iSelected} < (NUM_PORTS_WIDTH+1)'(NUM_PORTS));
    end else begin : gNoRangeCheck
        assign legalGrant = iActive;
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (legalGrant) stateNext = ISSUE;
            ISSUE:   if (iMemAck) stateNext = RESP;
            RESP:    stateNext = DRAIN;
            DRAIN:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        holdIdxD = holdIdx;
        holdWeD  = holdWe;
        addrD    = oMemAddr;
        wdataD   = oMemWriteData;
        rdataD   = oReadData;
        reqD     = 1'b0;
        weD      = 1'b0;
        validD   = '0;
        doneD    = '0;
        unique case (state)
            IDLE: begin
                if (legalGrant) begin
                    holdIdxD = iSelected;
                    holdWeD  = selWe[0];
                    addrD    = selAddr;
                    wdataD   = selData;
                    reqD     = 1'b1;
                    weD      = selWe[0];
                end
            end
            ISSUE: begin
                if (iMemAck) begin
                    if (holdWe) begin
                        doneD[holdIdx] = 1'b1;
                    end else begin
                        validD[holdIdx] = 1'b1;
                        rdataD          = iMemReadData;
                    end
                end else begin
                    reqD = 1'b1;
                    weD  = holdWe;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            holdIdx         <= '0;
            holdWe          <= 1'b0;
            oMemAddr        <= '0;
            oMemWriteData   <= '0;
            oMemRequest     <= 1'b0;
            oMemWriteEnable <= 1'b0;
            oReadData       <= '0;
            oReadValid      <= '0;
            oWriteDone      <= '0;
        end else begin
            holdIdx         <= holdIdxD;
            holdWe          <= holdWeD;
            oMemAddr        <= addrD;
            oMemWriteData   <= wdataD;
            oMemRequest     <= reqD;
            oMemWriteEnable <= weD;
            oReadData       <= rdataD;
            oReadValid      <= validD;
            oWriteDone      <= doneD;
        end
    end

    assign oPortBusy = (state == ISSUE) || (state == RESP);

endmodule
